// File: rtl/tv_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tv_pkg
//  Description : Shared types and constants for the test-vector sequencer:
//                FSM state enum, error counter width, address-width helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package tv_pkg;

  // Width of the saturating mismatch counter
  localparam int TV_ERR_W = 32;

  // Sequencer states; ST_ prefix keeps ST_SETTLE clear of the SETTLE parameter
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_APPLY  = 3'd2,
    ST_SETTLE = 3'd3,
    ST_CHECK  = 3'd4,
    ST_DONE   = 3'd5
  } tv_state_t;

  // Vector address width; a single-vector memory still gets a 1-bit address
  function automatic int tv_addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/tv_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : tv_sequencer_if
//  Description : Bundle between the sequencer, its vector memory, the DUT
//                under test and the controlling logic. The master modport is
//                the sequencer side; slave is the environment side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface tv_sequencer_if #(
  parameter int IN_W  = 8,
  parameter int OUT_W = 8,
  parameter int DEPTH = 16
);
  import tv_pkg::*;

  localparam int AW = tv_addr_w(DEPTH);

  logic                    start;
  logic [AW-1:0]           tv_addr;
  logic [IN_W+OUT_W-1:0]   tv_rdata;
  logic [IN_W-1:0]         dut_in;
  logic [OUT_W-1:0]        dut_out;
  logic                    busy;
  logic                    done;
  logic                    pass;
  logic [TV_ERR_W-1:0]     error_count;
  logic [AW-1:0]           first_fail_idx;

  modport master (
    input  start, tv_rdata, dut_out,
    output tv_addr, dut_in, busy, done, pass, error_count, first_fail_idx
  );

  modport slave (
    output start, tv_rdata, dut_out,
    input  tv_addr, dut_in, busy, done, pass, error_count, first_fail_idx
  );

endinterface
`default_nettype wire

// File: rtl/tv_settle_timer.sv
`default_nettype none
// ============================================================================
//  Module      : tv_settle_timer
//  Description : Loadable down-counter timing the settle window. load presets
//                SETTLE-1; dec counts down to zero and holds there.
//  Revision    : 1.0 - initial release
// ============================================================================
module tv_settle_timer #(
  parameter int SETTLE = 2
) (
  input  wire logic clk,
  input  wire logic reset,
  input  wire logic load,
  input  wire logic dec,
  output logic      zero
);

  localparam int            CW       = $clog2(SETTLE + 1);
  localparam logic [CW-1:0] LOAD_VAL = CW'(SETTLE - 1);

  logic [CW-1:0] count;

  // Preset on load, otherwise count down and stop at zero
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= LOAD_VAL;
    end else if (dec && (count != '0)) begin
      count <= count - CW'(1);
    end
  end

  assign zero = (count == '0);

endmodule
`default_nettype wire

// File: rtl/tv_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tv_sequencer
//  Description : Steps through DEPTH {input, expected} vectors, applies the
//                input half to a DUT, waits SETTLE cycles, compares the DUT
//                response with the expected half and counts mismatches.
//                Optional macro TV_STOP_ON_FAIL_EN ends the pass at the first
//                mismatch instead of running every vector.
//  Revision    : 1.0 - initial release
// ============================================================================
module tv_sequencer
  import tv_pkg::*;
#(
  parameter int IN_W   = 8,
  parameter int OUT_W  = 8,
  parameter int DEPTH  = 16,
  parameter int SETTLE = 2
) (
  input  wire logic      clk,
  input  wire logic      reset,
  tv_sequencer_if.master bus
);

  localparam int            AW       = tv_addr_w(DEPTH);
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  tv_state_t             state;
  tv_state_t             state_nx;
  logic [AW-1:0]         idx;
  logic [IN_W-1:0]       dut_in_q;
  logic [OUT_W-1:0]      expected;
  logic [TV_ERR_W-1:0]   err_cnt;
  logic [AW-1:0]         first_fail;
  logic                  timer_zero;
  logic                  mismatch;
  logic                  last_vec;
  logic                  accept_start;

  assign mismatch     = (state == ST_CHECK) && (bus.dut_out != expected);
  assign last_vec     = (idx == LAST_IDX);
  assign accept_start = bus.start && ((state == ST_IDLE) || (state == ST_DONE));

  tv_settle_timer #(
    .SETTLE (SETTLE)
  ) u_settle_timer (
    .clk   (clk),
    .reset (reset),
    .load  (state == ST_APPLY),
    .dec   (state == ST_SETTLE),
    .zero  (timer_zero)
  );

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state decode
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:   if (bus.start) state_nx = ST_FETCH;
      ST_FETCH:  state_nx = ST_APPLY;
      ST_APPLY:  state_nx = ST_SETTLE;
      ST_SETTLE: if (timer_zero) state_nx = ST_CHECK;
      ST_CHECK: begin
`ifdef TV_STOP_ON_FAIL_EN
        if (mismatch || last_vec) state_nx = ST_DONE;
        else                      state_nx = ST_FETCH;
`else
        if (last_vec) state_nx = ST_DONE;
        else          state_nx = ST_FETCH;
`endif
      end
      ST_DONE:   if (bus.start) state_nx = ST_FETCH;
      default:   state_nx = ST_IDLE;
    endcase
  end

  // Vector index, stimulus/expected capture and mismatch bookkeeping
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx        <= '0;
      dut_in_q   <= '0;
      expected   <= '0;
      err_cnt    <= '0;
      first_fail <= '0;
    end else if (accept_start) begin
      idx        <= '0;
      err_cnt    <= '0;
      first_fail <= '0;
    end else begin
      case (state)
        ST_APPLY: begin
          dut_in_q <= bus.tv_rdata[IN_W+OUT_W-1:OUT_W];
          expected <= bus.tv_rdata[OUT_W-1:0];
        end
        ST_CHECK: begin
          if (mismatch) begin
            if (err_cnt != '1) err_cnt <= err_cnt + TV_ERR_W'(1);
            if (err_cnt == '0) first_fail <= idx;
          end
          // idx only advances toward another vector; it never wraps here
          if (state_nx == ST_FETCH) idx <= idx + AW'(1);
        end
        default: ;
      endcase
    end
  end

  assign bus.tv_addr        = idx;
  assign bus.dut_in         = dut_in_q;
  assign bus.busy           = (state == ST_FETCH) || (state == ST_APPLY) ||
                              (state == ST_SETTLE) || (state == ST_CHECK);
  assign bus.done           = (state == ST_DONE);
  assign bus.pass           = (state == ST_DONE) && (err_cnt == '0);
  assign bus.error_count    = err_cnt;
  assign bus.first_fail_idx = first_fail;

endmodule
`default_nettype wire

// File: tb/tb_tv_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tv_sequencer
//  Description : Self-checking bench for tv_sequencer. Instance 0 runs
//                SETTLE=2 against a 1-cycle registered inverter; instances 1
//                and 2 run SETTLE=1 against 1- and 2-cycle inverters.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_tv_sequencer;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  tv_sequencer_if #(.IN_W(4), .OUT_W(4), .DEPTH(4)) bus0 ();
  tv_sequencer_if #(.IN_W(4), .OUT_W(4), .DEPTH(4)) bus1 ();
  tv_sequencer_if #(.IN_W(4), .OUT_W(4), .DEPTH(4)) bus2 ();

  tv_sequencer #(.IN_W(4), .OUT_W(4), .DEPTH(4), .SETTLE(2)) u0 (.clk(clk), .reset(reset), .bus(bus0));
  tv_sequencer #(.IN_W(4), .OUT_W(4), .DEPTH(4), .SETTLE(1)) u1 (.clk(clk), .reset(reset), .bus(bus1));
  tv_sequencer #(.IN_W(4), .OUT_W(4), .DEPTH(4), .SETTLE(1)) u2 (.clk(clk), .reset(reset), .bus(bus2));

  // Vector memories with one-cycle read latency
  logic [7:0] mem0 [4];
  logic [7:0] mem1 [4];
  always @(posedge clk) bus0.tv_rdata <= mem0[bus0.tv_addr];
  always @(posedge clk) bus1.tv_rdata <= mem1[bus1.tv_addr];
  always @(posedge clk) bus2.tv_rdata <= mem1[bus2.tv_addr];

  // DUT models: registered inverters, 1-cycle (bus0/bus1) and 2-cycle (bus2)
  logic [3:0] s1_2;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      bus0.dut_out <= 4'h0;
      bus1.dut_out <= 4'h0;
      bus2.dut_out <= 4'h0;
      s1_2         <= 4'h0;
    end else begin
      bus0.dut_out <= ~bus0.dut_in;
      bus1.dut_out <= ~bus1.dut_in;
      s1_2         <= ~bus2.dut_in;
      bus2.dut_out <= s1_2;
    end
  end

  typedef struct {
    logic [31:0] vecs;   // vector 0 in bits 31:24
    int          err;
    int          ffi;
    int          pss;
    int          cyc;
    int          din;
  } rec_t;

  rec_t recs [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic load_mem0(input logic [31:0] v);
    for (int i = 0; i < 4; i++) mem0[i] = v[31-8*i -: 8];
  endtask

  task automatic set_start(input int sel, input logic v);
    case (sel)
      0:       bus0.start = v;
      1:       bus1.start = v;
      default: bus2.start = v;
    endcase
  endtask

  function automatic logic get_done(input int sel);
    case (sel)
      0:       return bus0.done;
      1:       return bus1.done;
      default: return bus2.done;
    endcase
  endfunction

  // Pulses start, then counts edges until done (bounded)
  task automatic run_pass(input int sel, output int cyc);
    set_start(sel, 1'b1);
    @(posedge clk); #1;
    set_start(sel, 1'b0);
    cyc = 0;
    while (!get_done(sel) && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic check_result(input int sel, input string tag, input rec_t r, input int cyc);
    logic [31:0] err, ffi, pss, busy, din;
    case (sel)
      0:       begin err = bus0.error_count; ffi = 32'(bus0.first_fail_idx); pss = 32'(bus0.pass); busy = 32'(bus0.busy); din = 32'(bus0.dut_in); end
      1:       begin err = bus1.error_count; ffi = 32'(bus1.first_fail_idx); pss = 32'(bus1.pass); busy = 32'(bus1.busy); din = 32'(bus1.dut_in); end
      default: begin err = bus2.error_count; ffi = 32'(bus2.first_fail_idx); pss = 32'(bus2.pass); busy = 32'(bus2.busy); din = 32'(bus2.dut_in); end
    endcase
    chk({tag, " cycles"},      32'(cyc),  32'(r.cyc));
    chk({tag, " error_count"}, err,       32'(r.err));
    chk({tag, " first_fail"},  ffi,       32'(r.ffi));
    chk({tag, " pass"},        pss,       32'(r.pss));
    chk({tag, " busy"},        busy,      32'd0);
    chk({tag, " dut_in"},      din,       32'(r.din));
  endtask

  initial begin
    int   cyc;
    rec_t r_ok;
    rec_t r_two;

    // {vectors, err, ffi, pass, cycles, last dut_in}
    recs[0] = '{32'h3CA5F069, 0, 0, 1, 20, 6};
`ifdef TV_STOP_ON_FAIL_EN
    recs[1] = '{32'h3CA4F068, 1, 1, 0, 10, 'hA};
    recs[2] = '{32'h3DA5F069, 1, 0, 0,  5, 3};
    recs[3] = '{32'h30A0F56A, 1, 0, 0,  5, 3};
`else
    recs[1] = '{32'h3CA4F068, 2, 1, 0, 20, 6};
    recs[2] = '{32'h3DA5F069, 1, 0, 0, 20, 6};
    recs[3] = '{32'h30A0F56A, 4, 0, 0, 20, 6};
`endif
    recs[4] = recs[1];
    recs[5] = recs[0];
    r_ok    = recs[0];
    r_two   = recs[1];

    bus0.start = 1'b0;
    bus1.start = 1'b0;
    bus2.start = 1'b0;
    load_mem0(r_ok.vecs);
    for (int i = 0; i < 4; i++) mem1[i] = r_ok.vecs[31-8*i -: 8];

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    chk("reset tv_addr",     32'(bus0.tv_addr), 0);
    chk("reset dut_in",      32'(bus0.dut_in), 0);
    chk("reset error_count", bus0.error_count, 0);
    chk("reset first_fail",  32'(bus0.first_fail_idx), 0);
    chk("reset busy_done_pass", {29'd0, bus0.busy, bus0.done, bus0.pass}, 0);
    @(negedge clk) reset = 1'b0;

    // Reset during SETTLE of vector 2 aborts the pass
    @(posedge clk); #1;
    bus0.start = 1'b1;
    @(posedge clk); #1;        // E0: IDLE -> FETCH
    bus0.start = 1'b0;
    chk("run busy", 32'(bus0.busy), 1);
    repeat (12) @(posedge clk);
    #1;                         // after E12: vector 2 in SETTLE
    chk("mid tv_addr", 32'(bus0.tv_addr), 2);
    chk("mid dut_in",  32'(bus0.dut_in), 'hF);
    reset = 1'b1;
    #1;
    chk("abort tv_addr", 32'(bus0.tv_addr), 0);
    chk("abort dut_in",  32'(bus0.dut_in), 0);
    chk("abort flags",   {29'd0, bus0.busy, bus0.done, bus0.pass}, 0);
    @(negedge clk) reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("abort stays idle", 32'(bus0.busy), 0);
    run_pass(0, cyc);
    check_result(0, "rerun", r_ok, cyc);

    // Table of passes, each restarted from DONE
    for (int i = 0; i < 6; i++) begin
      load_mem0(recs[i].vecs);
      run_pass(0, cyc);
      check_result(0, $sformatf("rec%0d", i), recs[i], cyc);
    end

    // start pulsed during APPLY is ignored
    load_mem0(r_two.vecs);
    bus0.start = 1'b1;
    @(posedge clk); #1;        // E0
    bus0.start = 1'b0;
    @(posedge clk); #1;        // E1: FETCH
    @(posedge clk); #1;        // E2: APPLY
    bus0.start = 1'b1;
    @(posedge clk); #1;        // E3
    bus0.start = 1'b0;
    cyc = 3;
    while (!bus0.done && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    check_result(0, "apply_start", r_two, cyc);

    // SETTLE=1: 1-cycle DUT passes, 2-cycle DUT samples too early
    begin
      rec_t r1, r2;
      r1 = '{r_ok.vecs, 0, 0, 1, 16, 6};
`ifdef TV_STOP_ON_FAIL_EN
      r2 = '{r_ok.vecs, 1, 0, 0, 4, 3};
`else
      r2 = '{r_ok.vecs, 4, 0, 0, 16, 6};
`endif
      run_pass(1, cyc);
      check_result(1, "settle1_lat1", r1, cyc);
      run_pass(2, cyc);
      check_result(2, "settle1_lat2", r2, cyc);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
